gpr_sb_regfile: RTL and testbench
=================================

# gpr_sb_regfile

Parametrised general-purpose register file for the MIPS32 pipeline, successor to the two-read/one-write GPR. Provides NUM_RD combinational read ports with write-through bypass, two write ports for dual writeback (ALU and load paths), and a per-register scoreboard of pending writes. The scoreboard generates a stall request for reads of registers whose producer has issued but not yet written back. It sits between ID (reads and issue) and WB (writes).

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth is 2**ADDR_W, register 0 hard-wired to zero
- NUM_RD, 2, number of read ports
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- rd_en_i  in  NUM_RD  per-port read enable
- rd_addr_i  in  NUM_RD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W]
- rd_data_o  out  NUM_RD*DATA_W  read data, combinational; port k uses bits [k*DATA_W +: DATA_W]
- rd_busy_o  out  NUM_RD  addressed register has an outstanding write
- stall_o  out  1  OR over k of (rd_en_i[k] & rd_busy_o[k])
- wr0_en_i, wr0_addr_i, wr0_data_i  in  1/ADDR_W/DATA_W  writeback port 0 (older)
- wr1_en_i, wr1_addr_i, wr1_data_i  in  1/ADDR_W/DATA_W  writeback port 1 (younger)
- iss_en_i  in  1  issue: mark destination pending
- iss_addr_i  in  ADDR_W  issued destination
- pend_cnt_o  out  ADDR_W+1  registered count of pending registers

## Operation
- Storage: 2**ADDR_W x DATA_W array plus busy bit per entry. Entry 0 is never written, never busy, always reads 0.
- Write: on the edge, for each port with en=1, addr!=0, rst=0, the array takes the data. If both ports hit the same address, wr1 wins.
- Read, port k, in priority order:
  - rst=1 -> 0.
  - addr=0 -> 0.
  - rd_en=0 -> 0.
  - wr1 hits the address -> wr1_data.
  - wr0 hits the address -> wr0_data.
  - Otherwise -> array contents.
- Scoreboard next-state per entry r!=0:
  - Set if iss_en_i and iss_addr_i==r.
  - Else cleared if any write port hits r.
  - Else hold.
- Issue beats writeback when both target the same register in the same cycle: the new producer stays pending.
- Issue to an already-busy register keeps it busy.
- Writeback to a non-busy register writes data; busy stays 0.
- rd_busy_o[k] = busy[addr_k] & ~(any write port hits addr_k this cycle) & (addr_k!=0). Same-cycle writeback is satisfied by the bypass. During rst it is 0.
- pend_cnt_o: next value = current + (entries set from 0) - (entries cleared from 1). Range 0..2**ADDR_W-1; no wrap. A double write to one address counts as one clear.

## Timing
- Reads, bypass, rd_busy_o and stall_o are zero-latency combinational.
- A write is visible through bypass in the same cycle and from the array from the next cycle.
- An issue is visible on rd_busy_o and pend_cnt_o one cycle after the edge.
- Reset values:
  - All busy bits 0.
  - pend_cnt_o 0.
  - rd_data_o, rd_busy_o and stall_o are 0 while rst is high.
  - Array contents are set by the configuration below.
- Reset mid-operation: pending entries are dropped. Writes and issues presented in a cycle with rst=1 are ignored.

## Configuration
- GPR_RESET_CLEAR_EN defined: the array is synchronously zeroed on every rst edge, so every entry reads 0 after reset.
- GPR_RESET_CLEAR_EN undefined: reset does not touch the array; contents persist across reset (no reset fan-out, RAM-inferable). Busy bits and pend_cnt_o reset in both builds.

## Test plan
- Write wr0 r3=0x1234_5678; next cycle read port 0 r3 -> 0x1234_5678. Read r0 after a write to r0 -> 0.
- Same cycle wr0 r5=0xAAAA_AAAA and wr1 r5=0x5555_5555, read r5 -> bypass 0x5555_5555; next cycle array -> 0x5555_5555.
- Issue r7:
  - Next cycle read r7 -> rd_busy_o=1, stall_o=1, pend_cnt_o=1.
  - wr0 r7=0x42 with read r7 in the same cycle -> data 0x42, busy 0, stall 0.
  - Next cycle pend_cnt_o=0.
- Issue r9 while r9 is busy and wr1 writes r9 in the same cycle -> r9 still busy next cycle, pend_cnt_o unchanged at 1.
- Issue r1, r2, r3 on successive cycles (pend_cnt_o=3), then rst for 1 cycle:
  - During rst: stall_o=0.
  - After rst: pend_cnt_o=0, all busy 0.
  - r1 reads 0 with GPR_RESET_CLEAR_EN; otherwise it reads its prior value.
- Read port with rd_en_i=0 on a busy register -> data 0, stall_o=0.

Source files
------------

// File: rtl/gpr_sb_regfile.sv
// gpr_sb_regfile: MIPS32 general-purpose register file with NUM_RD
// combinational read ports, write-through bypass, two writeback ports
// (wr0 older, wr1 younger) and a per-register scoreboard of pending writes.
// Register 0 is hard-wired to zero and is never busy.
//
// Build option:
//   GPR_RESET_CLEAR_EN  - when defined, the array is zeroed on every rst edge.
//                         When undefined, reset leaves the array untouched so
//                         the storage stays RAM-inferable.
// Busy bits and the pending counter are reset in both builds.
module gpr_sb_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD-1:0]        rd_en_i,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
    output logic [NUM_RD*DATA_W-1:0] rd_data_o,
    output logic [NUM_RD-1:0]        rd_busy_o,
    output logic                     stall_o,
    input  logic                     wr0_en_i,
    input  logic [ADDR_W-1:0]        wr0_addr_i,
    input  logic [DATA_W-1:0]        wr0_data_i,
    input  logic                     wr1_en_i,
    input  logic [ADDR_W-1:0]        wr1_addr_i,
    input  logic [DATA_W-1:0]        wr1_data_i,
    input  logic                     iss_en_i,
    input  logic [ADDR_W-1:0]        iss_addr_i,
    output logic [ADDR_W:0]          pend_cnt_o
);

    localparam int DEPTH = 2**ADDR_W;
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = '0;
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic [DEPTH-1:0]  set_vec;
    logic [DEPTH-1:0]  clr_vec;
    logic [CNT_W-1:0]  pend_q;
    logic [CNT_W-1:0]  pend_d;
    logic [CNT_W-1:0]  n_set;
    logic [CNT_W-1:0]  n_clr;
    logic [ADDR_W-1:0] rd_addr [NUM_RD];

    // Qualified write/issue strobes: register 0 and reset cycles never count.
    logic wr0_hit;
    logic wr1_hit;
    logic iss_hit;

    assign wr0_hit = wr0_en_i & (wr0_addr_i != ZERO_ADDR) & ~rst;
    assign wr1_hit = wr1_en_i & (wr1_addr_i != ZERO_ADDR) & ~rst;
    assign iss_hit = iss_en_i & (iss_addr_i != ZERO_ADDR) & ~rst;

`ifdef GPR_RESET_CLEAR_EN
    // Array update: cleared on reset, otherwise wr0 then wr1 so wr1 wins a tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr0_hit) mem[wr0_addr_i] <= wr0_data_i;
            if (wr1_hit) mem[wr1_addr_i] <= wr1_data_i;
        end
    end
`else
    // Array update: no reset fan-out; wr1 is applied last so it wins a tie.
    always_ff @(posedge clk) begin
        if (wr0_hit) mem[wr0_addr_i] <= wr0_data_i;
        if (wr1_hit) mem[wr1_addr_i] <= wr1_data_i;
    end
`endif

    // Per-entry set/clear requests; entry 0 never gets either.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        for (int r = 1; r < DEPTH; r++) begin
            set_vec[r] = iss_hit & (iss_addr_i == ADDR_W'(r));
            clr_vec[r] = (wr0_hit & (wr0_addr_i == ADDR_W'(r))) |
                         (wr1_hit & (wr1_addr_i == ADDR_W'(r)));
        end
    end

    // Scoreboard next state (issue beats writeback) and counter deltas.
    always_comb begin
        busy_d    = (busy_q & ~clr_vec) | set_vec;
        busy_d[0] = 1'b0;
        n_set     = '0;
        n_clr     = '0;
        for (int r = 1; r < DEPTH; r++) begin
            if (set_vec[r] && !busy_q[r]) n_set = n_set + CNT_ONE;
            if (clr_vec[r] && busy_q[r] && !set_vec[r]) n_clr = n_clr + CNT_ONE;
        end
        pend_d = pend_q + n_set - n_clr;
    end

    // Scoreboard and pending-count registers; reset drops all pending entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
            pend_q <= '0;
        end else begin
            busy_q <= busy_d;
            pend_q <= pend_d;
        end
    end

    // Unpack the read address bus into one address per port.
    always_comb begin
        for (int k = 0; k < NUM_RD; k++) begin
            rd_addr[k] = rd_addr_i[k*ADDR_W +: ADDR_W];
        end
    end

    // Read ports: same-cycle writeback bypasses the array and clears busy.
    always_comb begin
        rd_data_o = '0;
        rd_busy_o = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            if (!rst && (rd_addr[k] != ZERO_ADDR)) begin
                rd_busy_o[k] = busy_q[rd_addr[k]] &
                               ~(wr0_hit & (wr0_addr_i == rd_addr[k])) &
                               ~(wr1_hit & (wr1_addr_i == rd_addr[k]));
                if (rd_en_i[k]) begin
                    if (wr1_hit && (wr1_addr_i == rd_addr[k])) begin
                        rd_data_o[k*DATA_W +: DATA_W] = wr1_data_i;
                    end else if (wr0_hit && (wr0_addr_i == rd_addr[k])) begin
                        rd_data_o[k*DATA_W +: DATA_W] = wr0_data_i;
                    end else begin
                        rd_data_o[k*DATA_W +: DATA_W] = mem[rd_addr[k]];
                    end
                end
            end
        end
    end

    assign stall_o    = |(rd_en_i & rd_busy_o);
    assign pend_cnt_o = pend_q;

endmodule

// File: tb/tb_gpr_sb_regfile.sv
// tb_gpr_sb_regfile: directed literal checks from the register-file test plan,
// then randomized traffic compared every cycle against an array-based model.
module tb_gpr_sb_regfile;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NUM_RD = 2;
    localparam int DEPTH  = 32;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_RD-1:0]        rd_en;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     stall;
    logic                     wr0_en, wr1_en, iss_en;
    logic [ADDR_W-1:0]        wr0_addr, wr1_addr, iss_addr;
    logic [DATA_W-1:0]        wr0_data, wr1_data;
    logic [ADDR_W:0]          pend_cnt;

    int n_vec = 0;
    int n_err = 0;

    // Reference state: register values, which are defined, which are pending.
    logic [DATA_W-1:0] m_mem   [DEPTH];
    bit                m_known [DEPTH];
    bit                m_busy  [DEPTH];
    int                m_cnt   = 0;
    bit                m_ready = 1'b0;

    gpr_sb_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) dut (
        .clk(clk), .rst(rst),
        .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_data),
        .rd_busy_o(rd_busy), .stall_o(stall),
        .wr0_en_i(wr0_en), .wr0_addr_i(wr0_addr), .wr0_data_i(wr0_data),
        .wr1_en_i(wr1_en), .wr1_addr_i(wr1_addr), .wr1_data_i(wr1_data),
        .iss_en_i(iss_en), .iss_addr_i(iss_addr), .pend_cnt_o(pend_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one clock edge to the model using the inputs presented this cycle.
    function automatic void model_edge();
        if (rst) begin
            for (int r = 0; r < DEPTH; r++) begin
                m_busy[r] = 1'b0;
`ifdef GPR_RESET_CLEAR_EN
                m_mem[r]   = '0;
                m_known[r] = 1'b1;
`endif
            end
            m_ready = 1'b1;
        end else begin
            if (wr0_en && wr0_addr != 0) begin
                m_mem[wr0_addr] = wr0_data; m_known[wr0_addr] = 1'b1; m_busy[wr0_addr] = 1'b0;
            end
            if (wr1_en && wr1_addr != 0) begin
                m_mem[wr1_addr] = wr1_data; m_known[wr1_addr] = 1'b1; m_busy[wr1_addr] = 1'b0;
            end
            if (iss_en && iss_addr != 0) m_busy[iss_addr] = 1'b1;
        end
        m_cnt = 0;
        for (int r = 0; r < DEPTH; r++) if (m_busy[r]) m_cnt++;
    endfunction

    function automatic bit exp_busy(input int k);
        logic [ADDR_W-1:0] a;
        a = rd_addr[k*ADDR_W +: ADDR_W];
        return !rst && a != 0 && m_busy[a] &&
               !(wr0_en && wr0_addr == a) && !(wr1_en && wr1_addr == a);
    endfunction

    function automatic logic [DATA_W-1:0] exp_data(input int k, output bit known);
        logic [ADDR_W-1:0] a;
        a = rd_addr[k*ADDR_W +: ADDR_W];
        known = 1'b1;
        if (rst || a == 0 || !rd_en[k]) return '0;
        if (wr1_en && wr1_addr == a) return wr1_data;
        if (wr0_en && wr0_addr == a) return wr0_data;
        known = m_known[a];
        return m_mem[a];
    endfunction

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (m_ready) begin
            bit          kn;
            bit          st;
            logic [31:0] ed;
            st = 1'b0;
            for (int k = 0; k < NUM_RD; k++) begin
                ed = exp_data(k, kn);
                if (kn) chk("model_rd_data", 64'(rd_data[k*DATA_W +: DATA_W]), 64'(ed));
                chk("model_rd_busy", 64'(rd_busy[k]), 64'(exp_busy(k)));
                st = st | (rd_en[k] & exp_busy(k));
            end
            chk("model_stall", 64'(stall), 64'(st));
            chk("model_pend_cnt", 64'(pend_cnt), 64'(m_cnt));
        end
    end

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        rd_en = '0; rd_addr = '0;
        wr0_en = 1'b0; wr0_addr = '0; wr0_data = '0;
        wr1_en = 1'b0; wr1_addr = '0; wr1_data = '0;
        iss_en = 1'b0; iss_addr = '0;
    endtask

    task automatic rd(input int k, input logic [ADDR_W-1:0] a);
        rd_en[k] = 1'b1;
        rd_addr[k*ADDR_W +: ADDR_W] = a;
    endtask

    function automatic logic [ADDR_W-1:0] rnd_addr();
        if ($urandom_range(0, 2) == 0) return ADDR_W'($urandom_range(0, 3));
        return ADDR_W'($urandom_range(0, DEPTH-1));
    endfunction

    initial begin
        rst = 1'b1;
        idle();
        tick();
        tick();
        rst = 1'b0;

        // Write then read from the array; register 0 ignores writes.
        wr0_en = 1'b1; wr0_addr = 5'd3; wr0_data = 32'h1234_5678;
        tick(); idle(); rd(0, 5'd3); #2;
        chk("wr_then_rd_r3", 64'(rd_data[31:0]), 64'h1234_5678);
        wr0_en = 1'b1; wr0_addr = 5'd0; wr0_data = 32'hFFFF_FFFF;
        tick(); idle(); rd(1, 5'd0); #2;
        chk("r0_reads_zero", 64'(rd_data[63:32]), 64'h0);

        // Dual write to one register: wr1 wins in bypass and in the array.
        idle();
        wr0_en = 1'b1; wr0_addr = 5'd5; wr0_data = 32'hAAAA_AAAA;
        wr1_en = 1'b1; wr1_addr = 5'd5; wr1_data = 32'h5555_5555;
        rd(0, 5'd5); #2;
        chk("dual_wr_bypass", 64'(rd_data[31:0]), 64'h5555_5555);
        tick(); idle(); rd(0, 5'd5); #2;
        chk("dual_wr_array", 64'(rd_data[31:0]), 64'h5555_5555);

        // Issue r7, observe the stall, then resolve it by writeback.
        idle(); iss_en = 1'b1; iss_addr = 5'd7;
        tick(); idle(); rd(0, 5'd7); #2;
        chk("iss_busy", 64'(rd_busy[0]), 64'h1);
        chk("iss_stall", 64'(stall), 64'h1);
        chk("iss_pend", 64'(pend_cnt), 64'h1);
        tick(); idle(); rd(0, 5'd7);
        wr0_en = 1'b1; wr0_addr = 5'd7; wr0_data = 32'h42; #2;
        chk("wb_bypass_data", 64'(rd_data[31:0]), 64'h42);
        chk("wb_bypass_busy", 64'(rd_busy[0]), 64'h0);
        chk("wb_bypass_stall", 64'(stall), 64'h0);
        tick(); idle(); #2;
        chk("wb_pend_zero", 64'(pend_cnt), 64'h0);

        // Re-issue of a busy register racing its writeback stays pending.
        iss_en = 1'b1; iss_addr = 5'd9;
        tick(); idle();
        iss_en = 1'b1; iss_addr = 5'd9;
        wr1_en = 1'b1; wr1_addr = 5'd9; wr1_data = 32'h99;
        tick(); idle(); rd(0, 5'd9); #2;
        chk("iss_beats_wb_busy", 64'(rd_busy[0]), 64'h1);
        chk("iss_beats_wb_pend", 64'(pend_cnt), 64'h1);
        idle(); wr0_en = 1'b1; wr0_addr = 5'd9; wr0_data = 32'h9A;
        tick(); idle();

        // Three pending issues dropped by a mid-run reset.
        wr0_en = 1'b1; wr0_addr = 5'd1; wr0_data = 32'h0000_1111;
        tick(); idle();
        for (int i = 1; i <= 3; i++) begin
            iss_en = 1'b1; iss_addr = ADDR_W'(i);
            tick(); idle();
        end
        #2;
        chk("three_pend", 64'(pend_cnt), 64'h3);
        rst = 1'b1; rd(0, 5'd1); rd(1, 5'd2); #2;
        chk("rst_stall", 64'(stall), 64'h0);
        chk("rst_rd_data", 64'(rd_data[31:0]), 64'h0);
        tick(); rst = 1'b0; idle(); rd(0, 5'd1); rd(1, 5'd2); #2;
        chk("post_rst_pend", 64'(pend_cnt), 64'h0);
        chk("post_rst_busy0", 64'(rd_busy[0]), 64'h0);
        chk("post_rst_busy1", 64'(rd_busy[1]), 64'h0);
`ifdef GPR_RESET_CLEAR_EN
        chk("post_rst_r1", 64'(rd_data[31:0]), 64'h0);
`else
        chk("post_rst_r1", 64'(rd_data[31:0]), 64'h1111);
`endif

        // A disabled read port neither returns data nor stalls.
        idle(); iss_en = 1'b1; iss_addr = 5'd4;
        tick(); idle(); rd_addr[ADDR_W-1:0] = 5'd4; #2;
        chk("rd_dis_data", 64'(rd_data[31:0]), 64'h0);
        chk("rd_dis_stall", 64'(stall), 64'h0);
        chk("rd_dis_busy", 64'(rd_busy[0]), 64'h1);
        idle(); wr0_en = 1'b1; wr0_addr = 5'd4; wr0_data = 32'h4444;
        tick(); idle();

        // Randomized traffic with address bias toward collisions.
        for (int n = 0; n < 3000; n++) begin
            rst      = ($urandom_range(0, 63) == 0);
            rd_en    = NUM_RD'($urandom_range(0, 3));
            for (int k = 0; k < NUM_RD; k++) rd_addr[k*ADDR_W +: ADDR_W] = rnd_addr();
            wr0_en   = ($urandom_range(0, 1) == 1);
            wr0_addr = rnd_addr();
            wr0_data = $urandom;
            wr1_en   = ($urandom_range(0, 1) == 1);
            wr1_addr = rnd_addr();
            wr1_data = $urandom;
            iss_en   = ($urandom_range(0, 2) != 0);
            iss_addr = rnd_addr();
            tick();
        end
        rst = 1'b0;
        idle();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
